div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle radix-2 restoring divider with its sequencing FSM, for DIV/DIVU in the OpenMIPS core.
- Sits beside the EX stage. EX issues start and holds operands; EX raises its stall request while the divider is busy. The result goes to HI/LO through the existing whilo path.
- Produces one quotient bit per cycle and supports cancellation (annul) from the pipeline.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH; iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU; sampled only when start is accepted.
opdata1_i  in  WIDTH  dividend; sampled only when start is accepted.
opdata2_i  in  WIDTH  divisor; sampled only when start is accepted.
start_i  in  1  request divide; level-held by EX until ready_o seen.
annul_i  in  1  cancel in-flight divide (pipeline flush).
result_o  out  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
ready_o  out  1  result_o valid.
busy_o  out  1  high in states DIV_ON and DIV_BYZERO.

Behaviour:
- All outputs are registered.
- Reset (rst=0, async): state DIV_FREE, cnt=0, result_o=0, ready_o=0, busy_o=0. Reset mid-operation abandons the divide immediately; nothing is resumed.
- Internal state: 2-bit FSM; 6-bit cnt; 2*WIDTH+1-bit shift register dividend; WIDTH-bit divisor; latched sign bits of both operands.
- DIV_FREE:
  - If start_i=1 and annul_i=0 and opdata2_i=0 -> DIV_BYZERO.
  - If start_i=1 and annul_i=0 and opdata2_i!=0 -> DIV_ON. On this edge: latch signs; dividend <= {WIDTH'b0, |op1|, 1'b0}; divisor <= |op2|; cnt <= 0.
  - |x| is two's-complement negation when signed_div_i=1 and x[WIDTH-1]=1; otherwise x unchanged.
  - Otherwise remain. ready_o=0, result_o=0.
- DIV_BYZERO: next edge -> DIV_END with result_o=0, ready_o=1.
- DIV_ON, each edge:
  - annul_i=1: -> DIV_FREE, cnt=0, outputs stay 0. Annul has priority over iteration.
  - cnt<WIDTH: compute t = {1'b0, dividend[2W-1:W]} - {1'b0, divisor}.
    - If t[W]=1: dividend <= dividend<<1.
    - Else: dividend <= {t[W-1:0], dividend[W-1:0], 1'b1}.
    - cnt <= cnt+1.
  - cnt==WIDTH: quotient q = dividend[W-1:0]; remainder r = dividend[2W:W+1].
    - If signed and the operand signs differ, q <= -q.
    - If signed and the dividend is negative, r <= -r.
    - result_o <= {r, q}; ready_o <= 1; -> DIV_END; cnt <= 0.
- DIV_END:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0: -> DIV_FREE, ready_o <= 0, result_o <= 0.
  - annul_i is ignored in DIV_END.
- Latency, counting the edge that accepts start_i as edge 1:
  - Normal divide: ready_o rises after edge WIDTH+2 (edge 34 for WIDTH=32).
  - Divide by zero: ready_o rises after edge 2.
- Boundary conditions:
  - Signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (wraps; no trap).
  - Operand changes after acceptance have no effect.
  - start_i held high in DIV_END does not retrigger; a new divide requires one cycle of start_i=0 back in DIV_FREE.
  - start_i and annul_i both high in DIV_FREE: no start.

Test Plan:
1. DIVU 100/7, start held -> ready_o rises after edge 34; result_o = {32'd2, 32'd14}; busy_o high for edges 1-33.
2. DIV signed 0xFFFFFF9C(-100)/7 -> result_o = {0xFFFFFFFE, 0xFFFFFFF2}. Also 100/0xFFFFFFF9(-7) -> {0x00000002, 0xFFFFFFF2}.
3. Divide by zero, op1=0x1234, op2=0 -> ready_o after edge 2; result_o=0. Then drop start_i -> DIV_FREE, ready_o=0 next edge.
4. Annul at edge 10 of a DIVU 0xFFFFFFFF/3 -> DIV_FREE, ready_o never asserts. Next start of 9/3 returns {0, 3} at edge 34.
5. Reset asserted at edge 15 of a divide -> outputs 0 immediately, not waiting for an edge. After release, divide 0xFFFFFFFF/1 gives {0, 0xFFFFFFFF}.
6. Signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}. start_i held in DIV_END for 5 cycles -> result stable, no retrigger.

Source files
------------

// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   signed_div_i 1 = signed divide, 0 = unsigned; sampled when start is accepted
//   opdata1_i    dividend, sampled when start is accepted
//   opdata2_i    divisor, sampled when start is accepted
//   start_i      divide request, held until ready_o is seen
//   annul_i      cancels an in-flight divide
//   result_o     {remainder, quotient}
//   ready_o      result_o valid
//   busy_o       divider occupied (iterating or handling divide-by-zero)
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} state_e;
  localparam logic [5:0] LAST = 6'(WIDTH);
  state_e             state_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH:0]   dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic               neg1_q, neg2_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q, busy_q;
  logic [WIDTH-1:0]   abs1, abs2, quo, rem;
  logic [WIDTH:0]     t;
  assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  // t[WIDTH] is the borrow: set when the partial remainder is below the divisor
  assign t    = {1'b0, dividend_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
  // neg*_q already fold in the signed flag, so unsigned divides never fix up signs
  assign quo  = (neg1_q ^ neg2_q) ? -dividend_q[WIDTH-1:0] : dividend_q[WIDTH-1:0];
  assign rem  = neg1_q ? -dividend_q[2*WIDTH:WIDTH+1] : dividend_q[2*WIDTH:WIDTH+1];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (start_i && !annul_i) begin
            busy_q <= 1'b1;
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q    <= DIV_ON;
              neg1_q     <= signed_div_i && opdata1_i[WIDTH-1];
              neg2_q     <= signed_div_i && opdata2_i[WIDTH-1];
              dividend_q <= {{WIDTH{1'b0}}, abs1, 1'b0};
              divisor_q  <= abs2;
              cnt_q      <= '0;
            end
          end
        end
        DIV_BYZERO: begin
          state_q  <= DIV_END;
          result_q <= '0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
        DIV_ON: begin
          if (annul_i) begin
            state_q <= DIV_FREE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q != LAST) begin
            dividend_q <= t[WIDTH] ? {dividend_q[2*WIDTH-1:0], 1'b0}
                                   : {t[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
            cnt_q      <= cnt_q + 6'd1;
          end else begin
            result_q <= {rem, quo};
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DIV_END;
            cnt_q    <= '0;
          end
        end
        default: begin
          if (!start_i) begin
            state_q  <= DIV_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
      endcase
    end
  end
  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for the restoring divider
module tb_div;
  logic        clk, rst, signed_div_i, start_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o;
  logic [63:0] sb[$];
  int passed = 0, total = 0;

  div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'd0) return 64'd0;
    sa  = sd ? longint'($signed(a)) : longint'({32'd0, a});
    sbv = sd ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b, input bit push);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (push) sb.push_back(model(sd, a, b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int edges, output int busy_n);
    edges = 0;
    busy_n = 0;
    do begin
      step();
      edges++;
      if (busy_o) busy_n++;
    end while (!ready_o && edges < 100);
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #3;
    total++; if (result_o !== 64'd0) $display("FAIL reset_result got %h exp 0", result_o); else passed++;
    total++; if (ready_o !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_o); else passed++;
    #9 rst = 1'b1;
    step();
  endtask

  task automatic test_divu();
    int e, b;
    logic [63:0] exp;
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    wait_ready(e, b);
    total++; if (e != 34) $display("FAIL divu_latency got %0d exp 34", e); else passed++;
    total++; if (b != 33) $display("FAIL divu_busy_edges got %0d exp 33", b); else passed++;
    exp = sb.size() ? sb.pop_front() : 64'hx;
    total++; if (result_o !== exp) $display("FAIL divu_result got %h exp %h", result_o, exp); else passed++;
    start_i = 1'b0;
    step();
    total++; if (ready_o !== 1'b0 || result_o !== 64'd0) $display("FAIL divu_drop got %b/%h exp 0/0", ready_o, result_o); else passed++;
  endtask

  task automatic test_signed();
    int e, b;
    logic [63:0] exp;
    issue(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1);
    step();
    opdata1_i = 32'h12345678; opdata2_i = 32'h3; signed_div_i = 1'b0;
    wait_ready(e, b);
    total++; if (e + 1 != 34) $display("FAIL sdiv1_latency got %0d exp 34", e + 1); else passed++;
    exp = sb.size() ? sb.pop_front() : 64'hx;
    total++; if (result_o !== exp) $display("FAIL sdiv1_result got %h exp %h", result_o, exp); else passed++;
    start_i = 1'b0;
    step();
    issue(1'b1, 32'd100, 32'hFFFFFFF9, 1'b1);
    wait_ready(e, b);
    exp = sb.size() ? sb.pop_front() : 64'hx;
    total++; if (result_o !== exp) $display("FAIL sdiv2_result got %h exp %h", result_o, exp); else passed++;
    start_i = 1'b0;
    step();
  endtask

  task automatic test_byzero();
    int e, b;
    logic [63:0] exp;
    issue(1'b0, 32'h1234, 32'd0, 1'b1);
    wait_ready(e, b);
    total++; if (e != 2) $display("FAIL byzero_latency got %0d exp 2", e); else passed++;
    total++; if (b != 1) $display("FAIL byzero_busy_edges got %0d exp 1", b); else passed++;
    exp = sb.size() ? sb.pop_front() : 64'hx;
    total++; if (result_o !== exp) $display("FAIL byzero_result got %h exp %h", result_o, exp); else passed++;
    start_i = 1'b0;
    step();
    total++; if (ready_o !== 1'b0) $display("FAIL byzero_drop got %b exp 0", ready_o); else passed++;
  endtask

  task automatic test_annul();
    int e, b;
    bit seen;
    logic [63:0] exp;
    issue(1'b0, 32'hFFFFFFFF, 32'd3, 1'b0);
    for (int i = 0; i < 9; i++) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    total++; if (busy_o !== 1'b0) $display("FAIL annul_busy got %b exp 0", busy_o); else passed++;
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen |= ready_o;
    end
    total++; if (seen !== 1'b0) $display("FAIL annul_no_ready got %b exp 0", seen); else passed++;
    issue(1'b0, 32'd9, 32'd3, 1'b0);
    annul_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= busy_o;
    end
    total++; if (seen !== 1'b0) $display("FAIL start_with_annul got busy %b exp 0", seen); else passed++;
    annul_i = 1'b0;
    issue(1'b0, 32'd9, 32'd3, 1'b1);
    wait_ready(e, b);
    total++; if (e != 34) $display("FAIL after_annul_latency got %0d exp 34", e); else passed++;
    exp = sb.size() ? sb.pop_front() : 64'hx;
    total++; if (result_o !== exp) $display("FAIL after_annul_result got %h exp %h", result_o, exp); else passed++;
    start_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int e, b;
    logic [63:0] exp;
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 14; i++) step();
    total++; if (busy_o !== 1'b1) $display("FAIL pre_reset_busy got %b exp 1", busy_o); else passed++;
    #2 rst = 1'b0;
    start_i = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0)
      $display("FAIL async_reset got busy %b ready %b result %h exp 0/0/0", busy_o, ready_o, result_o); else passed++;
    #1 rst = 1'b1;
    step();
    issue(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
    wait_ready(e, b);
    exp = sb.size() ? sb.pop_front() : 64'hx;
    total++; if (result_o !== exp) $display("FAIL post_reset_result got %h exp %h", result_o, exp); else passed++;
    start_i = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int e, b;
    logic [63:0] exp;
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_ready(e, b);
    exp = sb.size() ? sb.pop_front() : 64'hx;
    total++; if (result_o !== exp) $display("FAIL overflow_result got %h exp %h", result_o, exp); else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || result_o !== exp)
        $display("FAIL hold_end got ready %b busy %b result %h exp 1/0/%h", ready_o, busy_o, result_o, exp); else passed++;
    end
    start_i = 1'b0;
    step();
    total++; if (ready_o !== 1'b0) $display("FAIL hold_drop got %b exp 0", ready_o); else passed++;
    step();
    total++; if (busy_o !== 1'b0) $display("FAIL no_retrigger got %b exp 0", busy_o); else passed++;
    issue(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1);
    wait_ready(e, b);
    exp = sb.size() ? sb.pop_front() : 64'hx;
    total++; if (result_o !== exp) $display("FAIL b2b_result got %h exp %h", result_o, exp); else passed++;
    start_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_byzero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    total++; if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
